// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the fetch side of the pipeline.
// Contents:
//   DATA_W, ADDR_W  default instruction word and PC widths
//   NOP_INSTR       word placed in IF/ID for a bubble or a flush
//   ST_*            2-bit encoding of the IF/ID fetch-tracking FSM
package mips_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

    // IDLE: nothing in flight, PEND: one read in flight, SKID: word parked
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SKID = 2'd2;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction word and its PC+1.
// Catches the word returned by instruction memory when ID stalls in the
// same cycle, so the returned data is never lost.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   load                  capture in_instr/in_pc_inc and mark valid
//   clear                 discard the entry (wins over load)
//   in_instr, in_pc_inc   word and PC+1 to park
//   instr, pc_inc, valid  parked contents
module if_skid_buf #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int ADDR_W = mips_pipe_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc_inc,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              valid
);
    import mips_pipe_pkg::*;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr  <= '0;
            pc_inc <= '0;
            valid  <= 1'b0;
        end else if (clear) begin
            instr  <= '0;
            pc_inc <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            instr  <= in_instr;
            pc_inc <= in_pc_inc;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with fetch tracking.
// Captures the PC+1 paired with each instruction-memory request, receives
// the word one cycle later and presents both to ID. A one-entry skid buffer
// absorbs the word that returns in the cycle ID first stalls. A branch
// flush kills the in-flight read and the skid entry and inserts a bubble.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   fetch_en        a fetch is requested this cycle
//   pc_inc_in       PC+1 of the address issued this cycle
//   imem_rdata      word for the address issued last cycle
//   stall_id        hold IF/ID
//   flush           taken branch/jump: kill wrong-path work
//   pc_write        PC may advance (combinational)
//   ifid_instr      IF/ID instruction
//   ifid_pc_inc     IF/ID PC+1
//   ifid_valid      IF/ID holds a real instruction
//   stall_cnt       saturating count of stalled cycles
module if_id_stage #(
    parameter int                DATA_W    = mips_pipe_pkg::DATA_W,
    parameter int                ADDR_W    = mips_pipe_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_inc_in,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall_id,
    input  logic              flush,
    output logic              pc_write,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_inc,
    output logic              ifid_valid,
    output logic [15:0]       stall_cnt
);
    import mips_pipe_pkg::*;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pend_pc_inc;
    logic              issue;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc_inc;
    logic              skid_valid;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Flush must let the PC load the branch target even when ID stalls.
    assign pc_write = flush | ~stall_id;

    // The wrong-path address presented during a flush is never requested.
    assign issue = fetch_en & pc_write & ~flush;

    // A stall while a read is in flight parks the returning word; releasing
    // the stall from SKID (or any flush) empties the buffer.
    assign skid_load  = (state == ST_PEND) & stall_id & ~flush;
    assign skid_clear = flush | ((state == ST_SKID) & ~stall_id);

    if_skid_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .in_instr  (imem_rdata),
        .in_pc_inc (pend_pc_inc),
        .instr     (skid_instr),
        .pc_inc    (skid_pc_inc),
        .valid     (skid_valid)
    );

    // Request stage: remember the PC+1 that goes with the in-flight read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_pc_inc <= '0;
        end else if (issue) begin
            pend_pc_inc <= pc_inc_in;
        end
    end

    // IF/ID register and fetch-tracking FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ifid_instr  <= NOP_INSTR;
            ifid_pc_inc <= '0;
            ifid_valid  <= 1'b0;
        end else if (flush) begin
            // ifid_pc_inc is left as is; only the instruction is killed
            state      <= ST_IDLE;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!stall_id) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                    state <= issue ? ST_PEND : ST_IDLE;
                end
                ST_PEND: begin
                    if (!stall_id) begin
                        ifid_instr  <= imem_rdata;
                        ifid_pc_inc <= pend_pc_inc;
                        ifid_valid  <= 1'b1;
                        state       <= issue ? ST_PEND : ST_IDLE;
                    end else begin
                        // pc_write is low, so nothing new is in flight
                        state <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (!stall_id) begin
                        ifid_instr  <= skid_instr;
                        ifid_pc_inc <= skid_pc_inc;
                        ifid_valid  <= skid_valid;
                        state       <= issue ? ST_PEND : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (stall_id) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: scripted fetch/stall/flush sequences with a
// synchronous instruction memory model. Expected IF/ID entries are queued
// by the stimulus; a negedge monitor pops and compares each new entry and
// checks hold, bubble, flush and pc_write behaviour every cycle.
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [15:0] pc_inc_in;
    logic [15:0] imem_rdata;
    logic        stall_id;
    logic        flush;
    logic        pc_write;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_inc;
    logic        ifid_valid;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t q[$];

    // bench-side model of the IF/ID contents
    logic        cur_valid = 1'b0;
    logic [15:0] cur_instr = 16'h0000;
    logic [15:0] cur_pc    = 16'h0000;

    logic s_edge;
    logic f_edge;

    if_id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_inc_in   (pc_inc_in),
        .imem_rdata  (imem_rdata),
        .stall_id    (stall_id),
        .flush       (flush),
        .pc_write    (pc_write),
        .ifid_instr  (ifid_instr),
        .ifid_pc_inc (ifid_pc_inc),
        .ifid_valid  (ifid_valid),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory word for PC+1 value n is the nibble n repeated: 1->1111, A->AAAA
    function automatic logic [15:0] mem_of(input logic [15:0] a);
        logic [3:0] n;
        n = a[3:0];
        return {n, n, n, n};
    endfunction

    always @(posedge clk) begin
        imem_rdata <= mem_of(pc_inc_in);
        s_edge     <= stall_id;
        f_edge     <= flush;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic fe, input logic [15:0] pc, input logic st, input logic fl);
        fetch_en  = fe;
        pc_inc_in = pc;
        stall_id  = st;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        q.push_back(e);
    endtask

    // monitor: judge what the last edge should have done from the inputs
    // the bench applied at that edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            cur_valid = 1'b0;
            cur_instr = 16'h0000;
            cur_pc    = 16'h0000;
        end else begin
            chk("pc_write", {31'd0, pc_write}, {31'd0, flush | ~stall_id});
            if (f_edge) begin
                chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
                chk("flush_instr", {16'd0, ifid_instr}, 32'h0000);
                chk("flush_pc", {16'd0, ifid_pc_inc}, {16'd0, cur_pc});
                cur_valid = 1'b0;
                cur_instr = 16'h0000;
            end else if (s_edge) begin
                chk("hold", {15'd0, ifid_valid, ifid_instr, ifid_pc_inc},
                    {15'd0, cur_valid, cur_instr, cur_pc});
            end else if (ifid_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_instr", {ifid_instr, ifid_pc_inc}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("ifid_entry", {ifid_instr, ifid_pc_inc}, {e.instr, e.pc});
                end
                cur_valid = 1'b1;
                cur_instr = ifid_instr;
                cur_pc    = ifid_pc_inc;
            end else begin
                chk("bubble_instr", {16'd0, ifid_instr}, 32'h0000);
                cur_valid = 1'b0;
                cur_instr = 16'h0000;
            end
        end
    end

    initial begin
        reset     = 1'b0;
        fetch_en  = 1'b0;
        pc_inc_in = 16'h0000;
        stall_id  = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", {16'd0, ifid_instr}, 32'h0000);
        chk("rst_pc", {16'd0, ifid_pc_inc}, 32'h0000);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // streaming fetch, one instruction per cycle
        push(16'h1111, 16'h1);
        push(16'h2222, 16'h2);
        push(16'h3333, 16'h3);
        cyc(1'b1, 16'h1, 1'b0, 1'b0);
        chk("lat_not_yet", {31'd0, ifid_valid}, 32'd0);
        cyc(1'b1, 16'h2, 1'b0, 1'b0);
        chk("lat_rise", {31'd0, ifid_valid}, 32'd1);
        cyc(1'b1, 16'h3, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // 3-cycle stall starting as the 2222 word returns
        push(16'h1111, 16'h1);
        push(16'h2222, 16'h2);
        push(16'h3333, 16'h3);
        cyc(1'b1, 16'h1, 1'b0, 1'b0);
        cyc(1'b1, 16'h2, 1'b0, 1'b0);
        cyc(1'b1, 16'h3, 1'b1, 1'b0);
        cyc(1'b1, 16'h3, 1'b1, 1'b0);
        cyc(1'b1, 16'h3, 1'b1, 1'b0);
        cyc(1'b1, 16'h3, 1'b0, 1'b0);
        chk("release_entry", {ifid_instr, ifid_pc_inc}, 32'h2222_0002);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // flush while PEND: AAAA must never reach IF/ID, target 5 follows
        push(16'h5555, 16'h5);
        cyc(1'b1, 16'hA, 1'b0, 1'b0);
        cyc(1'b1, 16'hB, 1'b0, 1'b1);
        chk("flush_pend_valid", {31'd0, ifid_valid}, 32'd0);
        chk("flush_pend_instr", {16'd0, ifid_instr}, 32'h0000);
        cyc(1'b1, 16'h5, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // flush together with stall while in SKID: parked 6666 is dropped
        push(16'h7777, 16'h7);
        cyc(1'b1, 16'h6, 1'b0, 1'b0);
        cyc(1'b1, 16'h7, 1'b1, 1'b0);
        cyc(1'b1, 16'h7, 1'b1, 1'b1);
        chk("flush_skid_valid", {31'd0, ifid_valid}, 32'd0);
        cyc(1'b1, 16'h7, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);

        // asynchronous reset while a word (8888) is parked in SKID
        cyc(1'b1, 16'h8, 1'b0, 1'b0);
        cyc(1'b1, 16'h9, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst_instr", {16'd0, ifid_instr}, 32'h0000);
        chk("arst_pc", {16'd0, ifid_pc_inc}, 32'h0000);
        chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'h0000);
        @(posedge clk);
        #1;
        stall_id = 1'b0;
        fetch_en = 1'b0;
        reset    = 1'b1;
        push(16'h9999, 16'h9);
        cyc(1'b1, 16'h9, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // stall counter saturation
        for (int i = 0; i < 65534; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stall_cnt_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("stall_cnt_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);

        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-side consumer of the program counter: captures the PC issued to the synchronous instruction memory and the returned instruction word, and presents them to ID as the IF/ID pipeline register.
- Tracks the one-cycle in-flight memory read and owns a 1-entry skid buffer, so an ID stall never loses a returned word.
- Drives the PC's advance enable.
- Handles branch flush by inserting a NOP bubble.

Parameters:
- DATA_W, 16, instruction word width.
- ADDR_W, 16, PC / PC+1 width.
- NOP_INSTR, 16'h0000, word inserted on bubble or flush.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  PC is valid and a fetch is requested this cycle.
- pc_inc_in  in  ADDR_W  PC+1 from the PC incrementer, paired with the address issued this cycle.
- imem_rdata  in  DATA_W  instruction word, valid the cycle after its address.
- stall_id  in  1  hazard unit: hold IF/ID.
- flush  in  1  branch/jump taken: kill wrong-path fetches.
- pc_write  out  1  PC may load its next value (combinational).
- ifid_instr  out  DATA_W  registered instruction to ID.
- ifid_pc_inc  out  ADDR_W  registered PC+1 to ID.
- ifid_valid  out  1  IF/ID holds a real instruction.
- stall_cnt  out  16  saturating count of cycles with stall_id=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - ifid_instr=NOP_INSTR, ifid_pc_inc=0, ifid_valid=0.
  - stall_cnt=0, state=IDLE, skid cleared.
- pc_write = flush | ~stall_id. Flush beats stall.
- Request issued in a cycle: fetch_en & pc_write & ~flush.
  - On issue, pend_pc_inc <= pc_inc_in.
  - The word returns on imem_rdata next cycle.
- States:
  - IDLE: nothing in flight, skid empty.
  - PEND: one read in flight.
  - SKID: a returned word is parked in skid_instr/skid_pc_inc.
- IDLE:
  - Issue -> PEND.
  - Else stay IDLE.
  - If ~stall_id, load a bubble (ifid_valid=0, ifid_instr=NOP_INSTR).
- PEND, ~stall_id:
  - IF/ID <= {imem_rdata, pend_pc_inc}, ifid_valid=1.
  - New issue -> PEND (back-to-back, 1 instr/cycle).
  - No new issue -> IDLE.
- PEND, stall_id:
  - skid <= {imem_rdata, pend_pc_inc}, IF/ID held -> SKID.
  - pc_write=0 this cycle, so no new request is in flight.
- SKID, stall_id: hold everything, stay SKID.
- SKID, ~stall_id:
  - IF/ID <= skid, ifid_valid=1.
  - Issue this cycle -> PEND, else IDLE.
  - No fetch cycle is lost on stall release.
- Skid overflow is impossible: requests are only issued when pc_write=1, and a request cannot be outstanding while in SKID.
- flush (any state, overrides stall):
  - ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc_inc unchanged.
  - Pending read and skid discarded -> IDLE.
  - The wrong-path request in the flush cycle is not issued.
  - The PC loads the target (pc_write=1); the target is fetched the following cycle.
- Latency: PC issued in cycle t appears on IF/ID at the edge ending cycle t+1 (visible in t+2) when unstalled.
- While stalled, the IF/ID contents and ifid_valid are bit-for-bit held.
- stall_cnt increments each cycle stall_id=1 and saturates at 16'hFFFF. Only reset clears it.
- Reset asserted mid-operation: all state returns to reset values immediately, including skid contents.

Decomposition:
- Shared package (mips_pipe_pkg):
  - NOP_INSTR constant.
  - DATA_W/ADDR_W widths.
  - 2-bit state encoding: IDLE=0, PEND=1, SKID=2.
- One natural sub-module: if_skid_buf, the 1-entry data+PC+valid holding register with load/clear.
- FSM and IF/ID register stay in the top.

Test Plan:
- Reset then fetch_en=1, pc_inc 1,2,3 with imem returning 16'h1111, 16'h2222, 16'h3333:
  - ifid_valid first rises 2 cycles after the first issue.
  - IF/ID shows (1111,1), (2222,2), (3333,3) on consecutive cycles.
- Stall for 3 cycles, asserted the cycle the 16'h2222 word returns:
  - pc_write=0 for those 3 cycles, ifid stays (1111,1).
  - On release IF/ID=(2222,2), next cycle (3333,3): no loss or duplicate.
  - stall_cnt=3.
- flush while PEND with 16'hAAAA returning:
  - Next cycle ifid_valid=0, ifid_instr=16'h0000, AAAA never appears.
  - pc_write=1 in the flush cycle.
- flush and stall_id together while in SKID:
  - Skid discarded, ifid_valid=0, pc_write=1, state returns to IDLE.
- Assert reset low mid-stream in SKID:
  - Outputs go to reset values asynchronously (before the next edge).
  - After release, the first valid IF/ID is the first fresh fetch.
- Hold stall_id=1 for 65540 cycles: stall_cnt saturates at 16'hFFFF.
